mux2_stream_arbiter: RTL and testbench
======================================

Name: mux2_stream_arbiter

Overview:
- Upstream control stage for the 2:1 multiplexer.
- Arbitrates between two valid/ready input streams (channel A and channel B) and drives the mux select `sel`, with 0 meaning A and 1 meaning B.
- Registers the selected word into a one-entry output stage with backpressure.
- Uses a bounded-burst round-robin policy, so one channel cannot starve the other.

Parameters:
- WIDTH, default 8: data width of a_data, b_data and y_data.
- MAX_BURST, default 2, legal range 1 or more: maximum number of consecutive grants to one channel while the other channel is requesting. MAX_BURST=1 gives strict alternation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a_data  input  WIDTH  channel A data.
- a_valid  input  1  channel A holds a word.
- a_ready  output  1  channel A word accepted this cycle.
- b_data  input  WIDTH  channel B data.
- b_valid  input  1  channel B holds a word.
- b_ready  output  1  channel B word accepted this cycle.
- sel  output  1  mux select; 0 selects A, 1 selects B.
- y_data  output  WIDTH  registered output word.
- y_valid  output  1  y_data holds a word.
- y_ready  input  1  downstream accepts y_data.

Interface decision (fixed): one clock, clk. Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asserted at any time, including mid-transfer):
  - y_valid=0, y_data=0, last_sel=0, burst_cnt=0, sel=0.
  - a_ready=0 and b_ready=0 while rst_n is low.
  - Any in-flight word is dropped.
- load = !y_valid || y_ready. The output slot is free, or is being drained in the same cycle.
- Grant is combinational and evaluated only when load=1:
  - Only a_valid set: grant A.
  - Only b_valid set: grant B.
  - Both set and burst_cnt < MAX_BURST: grant the channel last_sel.
  - Both set and burst_cnt == MAX_BURST: grant the other channel.
  - Neither set: no grant.
- Handshake outputs:
  - a_ready = load && grant==A; b_ready = load && grant==B. These never depend on y_ready except through load.
  - At most one of a_ready and b_ready is high in any cycle.
- sel equals the grant during a granted cycle. Otherwise sel holds last_sel, so the mux stays stable.
- On a grant, at the clock edge:
  - y_data <= selected data; y_valid <= 1.
  - If the grant equals last_sel, burst_cnt <= min(burst_cnt+1, MAX_BURST). Otherwise burst_cnt <= 1.
  - last_sel <= grant.
- On no grant with y_ready=1: y_valid <= 0. y_data holds its value.
- With y_valid=1 and y_ready=0: y_data, y_valid, last_sel and burst_cnt all hold.
- Latency: an input word appears on y_data 1 cycle after its handshake.
- Throughput: 1 word per cycle while y_ready=1 and any input is valid.
- Lone requester: burst_cnt saturates at MAX_BURST. If the other channel then requests, it wins on the next grant.
- burst_cnt width: $clog2(MAX_BURST+1).
- Inputs are not required to hold data stable between cycles. Only the value present at the handshake is captured.

Test Plan (WIDTH=8, MAX_BURST=2):
- Reset check: hold rst_n=0 with a_valid=b_valid=1.
  - Required: y_valid=0, y_data=0, sel=0, a_ready=b_ready=0.
  - Release reset. First grant is A (last_sel=0, burst_cnt=0), and y_data=a_data one cycle later.
- Both channels saturated: a_valid=b_valid=1 continuously, y_ready=1.
  - Required grant sequence: A,A,B,B,A,A.
  - y_data follows 1 cycle behind, with sel matching each grant.
- Lone requester: only A valid for 5 words (0x11..0x15), then B raises b_valid while A stays valid.
  - Required: all 5 A words pass back-to-back.
  - Next grant is B, then B again, then A.
- Backpressure: y_valid=1 with y_data=0x3C and y_ready=0 for 4 cycles while both inputs are valid.
  - Required: a_ready=b_ready=0 and y_data stays 0x3C.
  - When y_ready rises, the next word loads in the same cycle with no bubble.
- Drain to empty: single B word 0x7E, then no valid inputs.
  - Required: y_valid high for one cycle with y_ready=1, then y_valid=0.
  - y_data stays 0x7E and sel stays 1.
- Mid-operation reset: assert rst_n low asynchronously between edges while y_valid=1.
  - Required: y_valid drops immediately without waiting for a clock edge.
  - After release, arbitration restarts with A first.

Source files
------------

// File: rtl/mux2_stream_arbiter.sv
// rtl/mux2_stream_arbiter.sv - bounded-burst round-robin 2:1 stream arbiter with registered output slot
module mux2_stream_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic             sel,
   output logic [WIDTH-1:0] y_data,
   output logic             y_valid,
   input  logic             y_ready
);

   localparam int            CW        = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] BURST_ONE = CW'(1);

   logic [WIDTH-1:0] y_data_q, y_data_d;
   logic             y_valid_q, y_valid_d;
   logic             last_sel_q, last_sel_d;
   logic [CW-1:0]    burst_cnt_q, burst_cnt_d;

   logic             load;
   logic             grant_vld;
   logic             grant_sel;

   // Grant decision: only when the output slot can take a word; gated off while in reset
   always_comb begin
      load      = !y_valid_q || y_ready;
      grant_vld = 1'b0;
      grant_sel = last_sel_q;
      if (rst_n && load) begin
         if (a_valid && b_valid) begin
            grant_vld = 1'b1;
            grant_sel = (burst_cnt_q < BURST_MAX) ? last_sel_q : !last_sel_q;
         end else if (a_valid) begin
            grant_vld = 1'b1;
            grant_sel = 1'b0;
         end else if (b_valid) begin
            grant_vld = 1'b1;
            grant_sel = 1'b1;
         end
      end
   end

   // Handshakes and mux select; sel falls back to last_sel so the mux stays put when idle
   always_comb begin
      a_ready = grant_vld && !grant_sel;
      b_ready = grant_vld &&  grant_sel;
      sel     = grant_sel;
      y_data  = y_data_q;
      y_valid = y_valid_q;
   end

   // Next-state: capture granted word and advance burst tracking, or drain the slot
   always_comb begin
      y_data_d    = y_data_q;
      y_valid_d   = y_valid_q;
      last_sel_d  = last_sel_q;
      burst_cnt_d = burst_cnt_q;
      if (grant_vld) begin
         y_data_d   = grant_sel ? b_data : a_data;
         y_valid_d  = 1'b1;
         last_sel_d = grant_sel;
         if (grant_sel == last_sel_q) begin
            burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + BURST_ONE;
         end else begin
            burst_cnt_d = BURST_ONE;
         end
      end else if (y_ready) begin
         y_valid_d = 1'b0;
      end
   end

   // State registers; asynchronous reset drops any in-flight word immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_data_q    <= '0;
         y_valid_q   <= 1'b0;
         last_sel_q  <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         y_data_q    <= y_data_d;
         y_valid_q   <= y_valid_d;
         last_sel_q  <= last_sel_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// tb/tb_mux2_stream_arbiter.sv - directed and randomized checks of mux2_stream_arbiter against a grant-history model
module tb_mux2_stream_arbiter;

   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 2;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;
   logic             sel;
   logic [WIDTH-1:0] y_data;
   logic             y_valid;
   logic             y_ready;

   mux2_stream_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_data  (a_data),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .b_data  (b_data),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .sel     (sel),
      .y_data  (y_data),
      .y_valid (y_valid),
      .y_ready (y_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks_total;
   int checks_passed;

   // Reference model: list of past grants (0=A, 1=B) plus the output slot contents
   logic             hist[$];
   logic             m_yv;
   logic [WIDTH-1:0] m_yd;
   logic             obs_sel;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
   endtask

   task automatic chk8(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
   endtask

   // One clock cycle; entered and left at posedge+1
   task automatic cycle(input logic av, input logic [WIDTH-1:0] ad,
                        input logic bv, input logic [WIDTH-1:0] bd, input logic yr);
      logic ld, gv, g, lst;
      int   run;
      a_valid = av;
      a_data  = ad;
      b_valid = bv;
      b_data  = bd;
      y_ready = yr;
      #3;
      if (!rst_n) begin
         hist.delete();
         m_yv = 1'b0;
         m_yd = '0;
      end
      lst = (hist.size() > 0) ? hist[$] : 1'b0;
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != lst) break;
         run++;
      end
      if (run > MAX_BURST) run = MAX_BURST;
      ld = rst_n && (!m_yv || yr);
      gv = ld && (av || bv);
      if (av && bv) g = (run < MAX_BURST) ? lst : !lst;
      else          g = bv;
      chk1("a_ready", a_ready, gv && !g);
      chk1("b_ready", b_ready, gv && g);
      chk1("sel", sel, gv ? g : lst);
      chk1("y_valid", y_valid, m_yv);
      chk8("y_data", y_data, m_yd);
      obs_sel = sel;
      if (rst_n) begin
         if (gv) begin
            hist.push_back(g);
            if (hist.size() > 8) void'(hist.pop_front());
            m_yv = 1'b1;
            m_yd = g ? bd : ad;
         end else if (yr) begin
            m_yv = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0]  sat_pat;
      logic [31:0] r;
      checks_total  = 0;
      checks_passed = 0;
      m_yv    = 1'b0;
      m_yd    = '0;
      obs_sel = 1'b0;
      rst_n   = 1'b0;
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data  = 8'hA5;
      b_data  = 8'h5A;
      y_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset held with both inputs requesting
      cycle(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1);
      cycle(1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1);
      rst_n = 1'b1;

      // Saturated: grants A,A,B,B,A,A
      sat_pat = 6'b001100;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 8'h20 + 8'(i), 1'b1, 8'h40 + 8'(i), 1'b1);
         chk1("sat_grant", obs_sel, sat_pat[i]);
      end
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      // Lone requester A, then B joins: B,B,A
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 8'h11 + 8'(i), 1'b0, 8'hEE, 1'b1);
         chk1("lone_a_ready", obs_sel, 1'b0);
      end
      cycle(1'b1, 8'h16, 1'b1, 8'h61, 1'b1);
      chk1("join_1", obs_sel, 1'b1);
      cycle(1'b1, 8'h16, 1'b1, 8'h62, 1'b1);
      chk1("join_2", obs_sel, 1'b1);
      cycle(1'b1, 8'h16, 1'b1, 8'h63, 1'b1);
      chk1("join_3", obs_sel, 1'b0);

      // Backpressure holding 0x3C
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 8'h70 + 8'(i), 1'b1, 8'h80 + 8'(i), 1'b0);
         chk8("bp_hold", y_data, 8'h3C);
      end
      cycle(1'b1, 8'h90, 1'b1, 8'h91, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      // Drain to empty after a single B word
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 8'h7E, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk8("drain_data", y_data, 8'h7E);
      chk1("drain_sel", sel, 1'b1);

      // Mid-operation asynchronous reset
      cycle(1'b0, 8'h00, 1'b1, 8'hC3, 1'b0);
      chk1("pre_reset_valid", y_valid, 1'b1);
      a_valid = 1'b1;
      rst_n   = 1'b0;
      #1;
      chk1("async_y_valid", y_valid, 1'b0);
      chk8("async_y_data", y_data, 8'h00);
      chk1("async_a_ready", a_ready, 1'b0);
      chk1("async_b_ready", b_ready, 1'b0);
      @(posedge clk);
      #1;
      cycle(1'b1, 8'hD0, 1'b1, 8'hD1, 1'b1);
      rst_n = 1'b1;
      cycle(1'b1, 8'hD2, 1'b1, 8'hD3, 1'b1);
      chk1("restart_1", obs_sel, 1'b0);
      cycle(1'b1, 8'hD4, 1'b1, 8'hD5, 1'b1);
      chk1("restart_2", obs_sel, 1'b0);
      cycle(1'b1, 8'hD6, 1'b1, 8'hD7, 1'b1);
      chk1("restart_3", obs_sel, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom;
         cycle(r[0] | r[1], r[15:8], r[2] | r[3], r[23:16], r[4] | r[5] | r[6]);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
